// File: rtl/prbs_burst_sequencer_if.sv
// Burst request/response bundle for prbs_burst_sequencer: control fields in, serial PRBS out.
interface prbs_burst_sequencer_if #(
  parameter int unsigned DIV_W = 3,
  parameter int unsigned LEN_W = 8
);
  logic             ip_start;
  logic             ip_abort;
  logic [7:0]       ip_seed;
  logic [DIV_W-1:0] ip_div;
  logic [LEN_W-1:0] ip_len;
  logic             op_busy;
  logic             op_bit_valid;
  logic             op_prbs;
  logic             op_done;

  modport master (
    output ip_start, ip_abort, ip_seed, ip_div, ip_len,
    input  op_busy, op_bit_valid, op_prbs, op_done
  );

  modport slave (
    input  ip_start, ip_abort, ip_seed, ip_div, ip_len,
    output op_busy, op_bit_valid, op_prbs, op_done
  );
endinterface

// File: rtl/prbs_burst_sequencer.sv
// Emits a burst of len+1 PRBS bits (x^8+x^6+x^5+x^4 Fibonacci LFSR), one bit per div+1 clocks.
// Optional PRBS_SEQ_ERRCNT_EN adds a saturating receive-error counter.
module prbs_burst_sequencer #(
  parameter int unsigned DIV_W = 3,
  parameter int unsigned LEN_W = 8
) (
  input  logic                 ip_clock,
  input  logic                 ip_reset,
`ifdef PRBS_SEQ_ERRCNT_EN
  input  logic                 ip_rx_bit,
  output logic [7:0]           op_err_cnt,
`endif
  prbs_burst_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [7:0]       r_seed;
  logic [7:0]       r_lfsr;
  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] r_div_cnt;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_bit_cnt;

  logic w_fb;
  logic w_accept;

  assign w_fb     = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[4];
  assign w_accept = (r_state == S_IDLE) && bus.ip_start && !bus.ip_abort;

  // Busy stays high through the op_done cycle, which is spent back in IDLE.
  always_ff @(posedge ip_clock or negedge ip_reset) begin
    if (!ip_reset) begin
      r_state          <= S_IDLE;
      r_seed           <= 8'hFF;
      r_lfsr           <= 8'hFF;
      r_div            <= '0;
      r_div_cnt        <= '0;
      r_len            <= '0;
      r_bit_cnt        <= '0;
      bus.op_busy      <= 1'b0;
      bus.op_bit_valid <= 1'b0;
      bus.op_prbs      <= 1'b0;
      bus.op_done      <= 1'b0;
    end else begin
      bus.op_bit_valid <= 1'b0;
      bus.op_done      <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_state     <= S_LOAD;
            r_seed      <= (bus.ip_seed == 8'h00) ? 8'hFF : bus.ip_seed;
            r_div       <= bus.ip_div;
            r_len       <= bus.ip_len;
            bus.op_busy <= 1'b1;
          end else begin
            bus.op_busy <= 1'b0;
          end
        end
        S_LOAD: begin
          if (bus.ip_abort) begin
            r_state     <= S_IDLE;
            bus.op_busy <= 1'b0;
          end else begin
            r_lfsr    <= r_seed;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_state   <= S_RUN;
          end
        end
        S_RUN: begin
          if (bus.ip_abort) begin
            r_state     <= S_IDLE;
            bus.op_busy <= 1'b0;
          end else if (r_div_cnt == r_div) begin
            r_div_cnt        <= '0;
            bus.op_prbs      <= r_lfsr[0];
            r_lfsr           <= {w_fb, r_lfsr[7:1]};
            bus.op_bit_valid <= 1'b1;
            r_bit_cnt        <= r_bit_cnt + LEN_W'(1);
            if (r_bit_cnt == r_len) begin
              r_state <= S_DONE;
            end
          end else begin
            r_div_cnt <= r_div_cnt + DIV_W'(1);
          end
        end
        S_DONE: begin
          bus.op_done <= 1'b1;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef PRBS_SEQ_ERRCNT_EN
  // Compares the echoed bit against the bit currently on op_prbs during each strobe.
  always_ff @(posedge ip_clock or negedge ip_reset) begin
    if (!ip_reset) begin
      op_err_cnt <= 8'd0;
    end else if (w_accept) begin
      op_err_cnt <= 8'd0;
    end else if (bus.op_bit_valid && (ip_rx_bit != bus.op_prbs) && (op_err_cnt != 8'hFF)) begin
      op_err_cnt <= op_err_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_prbs_burst_sequencer.sv
// Directed bench for prbs_burst_sequencer: bit values, strobe timing, abort, reset, optional error counter.
module tb_prbs_burst_sequencer;

  localparam int unsigned DIV_W = 3;
`ifdef PRBS_SEQ_ERRCNT_EN
  localparam int unsigned TB_LEN_W = 9;
`else
  localparam int unsigned TB_LEN_W = 8;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  prbs_burst_sequencer_if #(.DIV_W(DIV_W), .LEN_W(TB_LEN_W)) bus ();

`ifdef PRBS_SEQ_ERRCNT_EN
  logic       rx_inv = 1'b0;
  logic       rx_bit;
  logic [7:0] err_cnt;
  int         inv_n = 0;
  assign rx_bit = bus.op_prbs ^ rx_inv;
`endif

  prbs_burst_sequencer #(.DIV_W(DIV_W), .LEN_W(TB_LEN_W)) dut (
    .ip_clock (clk),
    .ip_reset (rst_n),
`ifdef PRBS_SEQ_ERRCNT_EN
    .ip_rx_bit (rx_bit),
    .op_err_cnt(err_cnt),
`endif
    .bus      (bus)
  );

  int   total = 0;
  int   bad   = 0;
  int   stb_k[$];
  logic stb_b[$];
  int   done_k;
  int   busy_low_k;
  logic busy0;
  logic last_prbs;
  bit   hand_a5 [8] = '{1, 0, 1, 0, 0, 1, 0, 1};
  bit   hand_00 [9] = '{1, 1, 1, 1, 1, 1, 1, 1, 0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic model_bit(input logic [7:0] seed, input int idx);
    logic [7:0] s;
    s = (seed == 8'h00) ? 8'hFF : seed;
    for (int i = 0; i < idx; i++) s = {s[0] ^ s[2] ^ s[3] ^ s[4], s[7:1]};
    return s[0];
  endfunction

  // k counts rising edges after the edge that samples ip_start.
  task automatic run_burst(input logic [7:0] seed, input int div, input int len,
                           input int abort_k, input bit noisy, input int max_k);
    stb_k.delete();
    stb_b.delete();
    done_k     = -1;
    busy_low_k = -1;
    bus.ip_seed  = seed;
    bus.ip_div   = DIV_W'(div);
    bus.ip_len   = TB_LEN_W'(len);
    bus.ip_start = 1'b1;
    step();
    busy0 = bus.op_busy;
    if (noisy) begin
      bus.ip_seed = ~seed;
      bus.ip_div  = DIV_W'(~div);
      bus.ip_len  = TB_LEN_W'(~len);
    end else begin
      bus.ip_start = 1'b0;
    end
    for (int k = 1; k <= max_k; k++) begin
      step();
      if (bus.op_bit_valid) begin
`ifdef PRBS_SEQ_ERRCNT_EN
        rx_inv = (stb_k.size() < inv_n);
`endif
        stb_k.push_back(k);
        stb_b.push_back(bus.op_prbs);
      end
      if (!bus.op_busy && busy_low_k < 0) busy_low_k = k;
      last_prbs    = bus.op_prbs;
      bus.ip_abort = (k == abort_k);
      if (bus.op_done) begin
        done_k = k;
        break;
      end
    end
    bus.ip_start = 1'b0;
    bus.ip_abort = 1'b0;
  endtask

  task automatic chk_timing(input string tag, input int div, input int n);
    bit spacing_ok;
    chk({tag, "_count"}, stb_k.size(), n);
    if (stb_k.size() > 0) begin
      chk({tag, "_first"}, stb_k[0], div + 2);
      chk({tag, "_done"}, done_k, stb_k[stb_k.size()-1] + 1);
    end
    spacing_ok = 1'b1;
    for (int i = 1; i < stb_k.size(); i++)
      if (stb_k[i] - stb_k[i-1] != div + 1) spacing_ok = 1'b0;
    chk({tag, "_spacing"}, spacing_ok, 1'b1);
  endtask

  task automatic chk_bits(input string tag, input logic [7:0] seed);
    bit bits_ok;
    bits_ok = 1'b1;
    for (int i = 0; i < stb_b.size(); i++)
      if (stb_b[i] !== model_bit(seed, i)) bits_ok = 1'b0;
    chk({tag, "_bits"}, bits_ok, 1'b1);
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.ip_start = 1'b0;
    bus.ip_abort = 1'b0;
    bus.ip_seed  = 8'h00;
    bus.ip_div   = '0;
    bus.ip_len   = '0;
    #3;
    chk("rst_busy", bus.op_busy, 1'b0);
    chk("rst_valid", bus.op_bit_valid, 1'b0);
    chk("rst_prbs", bus.op_prbs, 1'b0);
    chk("rst_done", bus.op_done, 1'b0);
    step();
    step();
    rst_n = 1'b1;
    step();

    // seed A5, div 0, len 15
    run_burst(8'hA5, 0, 15, -1, 1'b0, 100);
    chk_timing("a5", 0, 16);
    for (int i = 0; i < 8 && i < stb_b.size(); i++) chk("a5_hand", stb_b[i], hand_a5[i]);
    chk_bits("a5", 8'hA5);
    step();
    chk("a5_idle_busy", bus.op_busy, 1'b0);
    chk("a5_done_pulse", bus.op_done, 1'b0);

    // zero seed substitution
    run_burst(8'h00, 0, 8, -1, 1'b0, 100);
    chk_timing("z0", 0, 9);
    for (int i = 0; i < 9 && i < stb_b.size(); i++) chk("z0_hand", stb_b[i], hand_00[i]);
    step();

    // div 3, len 2 with start held and fields scrambled mid-burst
    run_burst(8'h5C, 3, 2, -1, 1'b1, 100);
    chk("d3_busy_start", busy0, 1'b1);
    chk("d3_busy_low", busy_low_k, -1);
    chk("d3_n", stb_k.size(), 3);
    if (stb_k.size() == 3) begin
      chk("d3_s0", stb_k[0], 5);
      chk("d3_s1", stb_k[1], 9);
      chk("d3_s2", stb_k[2], 13);
    end
    chk("d3_done", done_k, 14);
    chk_bits("d3", 8'h5C);
    step();
    chk("d3_busy_after", bus.op_busy, 1'b0);

    // abort two cycles after the first strobe
    run_burst(8'h33, 3, 10, 7, 1'b0, 30);
    chk("ab_n", stb_k.size(), 1);
    chk("ab_busy_low", busy_low_k, 8);
    chk("ab_no_done", done_k, -1);
    chk("ab_prbs_hold", last_prbs, model_bit(8'h33, 0));

    // abort during DONE is ignored
    run_burst(8'hC3, 0, 2, 4, 1'b0, 30);
    chk("abd_n", stb_k.size(), 3);
    chk("abd_done", done_k, 5);
    step();

    // start with abort in IDLE stays idle
    bus.ip_start = 1'b1;
    bus.ip_abort = 1'b1;
    step();
    chk("sa_busy", bus.op_busy, 1'b0);
    bus.ip_start = 1'b0;
    bus.ip_abort = 1'b0;
    step();
    step();
    chk("sa_valid", bus.op_bit_valid, 1'b0);
    chk("sa_busy2", bus.op_busy, 1'b0);

    // reset mid-RUN
    run_burst(8'h3C, 1, 20, -1, 1'b0, 7);
    chk("mr_busy_pre", bus.op_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("mr_busy", bus.op_busy, 1'b0);
    chk("mr_prbs", bus.op_prbs, 1'b0);
    chk("mr_valid", bus.op_bit_valid, 1'b0);
    chk("mr_done", bus.op_done, 1'b0);
    step();
    rst_n = 1'b1;
    step();
    step();
    chk("mr_idle", bus.op_busy, 1'b0);
    run_burst(8'h5A, 0, 5, -1, 1'b0, 100);
    chk_timing("mr_new", 0, 6);
    chk_bits("mr_new", 8'h5A);
    step();

`ifdef PRBS_SEQ_ERRCNT_EN
    inv_n = 10;
    run_burst(8'h81, 0, 19, -1, 1'b0, 100);
    step();
    step();
    chk("ec_10", err_cnt, 8'd10);
    inv_n = 1000;
    run_burst(8'h81, 0, 299, -1, 1'b0, 400);
    step();
    chk("ec_sat", err_cnt, 8'd255);
    rx_inv = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/prbs_burst_sequencer.md
PRBS_BURST_SEQUENCER -- requirements
Module: prbs_burst_sequencer

Interface
REQ-001 Parameter DIV_W, default 3: width of the bit-period divider field.
REQ-002 Parameter LEN_W, default 8: width of the burst-length field.
REQ-003 ip_clock  input  1  single clock; all state updates on the rising edge.
REQ-004 ip_reset  input  1  reset, asynchronous, active-low.
REQ-005 ip_start  input  1  burst request; sampled only in IDLE.
REQ-006 ip_abort  input  1  terminates an active burst.
REQ-007 ip_seed  input  8  LFSR seed, captured on accepted start.
REQ-008 ip_div  input  DIV_W  bit period minus one, in clocks; captured on accepted start.
REQ-009 ip_len  input  LEN_W  burst bit count minus one; captured on accepted start.
REQ-010 op_busy  output  1  high while state is LOAD, RUN or DONE.
REQ-011 op_bit_valid  output  1  one-cycle strobe marking a new op_prbs bit.
REQ-012 op_prbs  output  1  serial PRBS bit; holds between strobes.
REQ-013 op_done  output  1  one-cycle pulse at normal burst completion.

Function
REQ-014 The FSM SHALL have states IDLE, LOAD, RUN and DONE.
REQ-015 IDLE -> LOAD when ip_start=1 and ip_abort=0; if both are high in IDLE, abort wins and the state stays IDLE.
REQ-016 On leaving IDLE, the block SHALL capture seed_q=ip_seed, div_q=ip_div and len_q=ip_len; a zero seed SHALL be replaced by 8'hFF.
REQ-017 LOAD lasts exactly one cycle: load lfsr=seed_q, clear div_cnt and bit_cnt, then go to RUN.
REQ-018 In RUN, div_cnt increments each cycle; when div_cnt==div_q, div_cnt wraps to 0 and a bit step occurs.
REQ-019 Bit step: op_prbs<=lfsr[0]; lfsr<={fb,lfsr[7:1]} with fb=lfsr[0]^lfsr[2]^lfsr[3]^lfsr[4]; op_bit_valid=1 in the following cycle; bit_cnt increments.
REQ-020 The bit step where bit_cnt==len_q SHALL move the FSM to DONE, so the burst emits exactly len_q+1 bits.
REQ-021 First op_bit_valid SHALL be asserted div_q+2 cycles after the cycle in which ip_start was sampled; subsequent strobes SHALL occur every div_q+1 cycles.
REQ-022 DONE lasts one cycle with op_done=1 (the cycle after the last op_bit_valid), then the FSM returns to IDLE.
REQ-023 ip_abort=1 in LOAD or RUN SHALL return the FSM to IDLE at the next edge, with no op_done and no further strobes; op_prbs holds its value.
REQ-024 ip_abort in DONE is ignored and op_done still pulses.
REQ-025 ip_start while op_busy=1 is ignored; captured fields SHALL NOT change mid-burst.
REQ-026 Counters are sized to their fields: div_cnt is DIV_W bits and bit_cnt is LEN_W bits; wrap only as specified above.

Reset
REQ-027 ip_reset=0 SHALL asynchronously force state=IDLE, lfsr=8'hFF, div_cnt=0, bit_cnt=0, op_prbs=0, op_bit_valid=0, op_done=0 and op_busy=0.
REQ-028 Reset asserted mid-burst discards the burst; after release, the block waits for a new ip_start.

Configuration
REQ-029 Macro PRBS_SEQ_ERRCNT_EN, when defined, SHALL add input ip_rx_bit (1 bit) and output op_err_cnt (8 bits).
REQ-030 With the macro defined, in every cycle where op_bit_valid=1, ip_rx_bit!=op_prbs SHALL increment op_err_cnt, saturating at 255.
REQ-031 With the macro defined, op_err_cnt SHALL clear to 0 on reset and on accepted start, and hold its value after the burst.
REQ-032 Without the macro, neither port nor the counter logic exists, and all other behaviour is identical.

Verification
REQ-033 seed=8'hA5, div=0, len=15, single start -> 16 strobes on consecutive cycles, first 8 bits 1,0,1,0,0,1,0,1, op_done one cycle after the 16th strobe.
REQ-034 seed=8'h00, div=0, len=8 -> bits 1,1,1,1,1,1,1,1,0 (zero-seed substitution to 8'hFF).
REQ-035 div=3, len=2 -> strobes at 5, 9 and 13 cycles after the start cycle; op_busy high from start+1 through the op_done cycle.
REQ-036 Abort asserted two cycles after the first strobe -> FSM back in IDLE next cycle, no op_done, op_prbs unchanged; start and abort together in IDLE -> stays IDLE.
REQ-037 ip_reset pulsed low mid-RUN -> all outputs 0 immediately, op_busy=0; a new start then produces a full burst from the new seed.
REQ-038 With PRBS_SEQ_ERRCNT_EN defined: ip_rx_bit=~op_prbs for 10 bits of a 20-bit burst -> op_err_cnt=10; inverted for a 300-bit burst -> op_err_cnt=255.
